demux_stream_n: RTL and testbench
=================================

Name: demux_stream_n

Overview:
- Parametrised, registered 1-to-N stream demultiplexer.
- Successor to the team's combinational 1-to-8 bit demux: multi-bit data, N channels, valid/ready handshake on every port, a one-entry output register per channel, a broadcast mode, and out-of-range select detection.
- Sits between a single producer and N independent consumers; each consumer can back-pressure independently.

Parameters:
- DW, 8, data width in bits (>=1).
- N, 8, number of output channels (>=2; need not be a power of two).
- SW, $clog2(N), select width; localparam derived from N, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block accepts the word this cycle.
- in_data  input  DW  payload.
- in_sel  input  SW  destination channel index.
- in_bcast  input  1  1 = deliver to all N channels; in_sel ignored.
- out_valid  output  N  per-channel word available.
- out_ready  input  N  per-channel consumer accepts.
- out_data  output  N*DW  channel i occupies bits [i*DW +: DW].
- sel_err  output  1  one-cycle pulse: a word with in_sel >= N (and in_bcast=0) was dropped.

Behaviour:
- One clock; reset is synchronous and active-low: rst_n sampled low at a clk rising edge clears state.
- Reset values: out_valid all 0; out_data all 0; sel_err 0.
- in_ready during reset is don't-care; the producer must not rely on it.
- Per-channel slot i holds one word (valid_i, data_i).
  - free_i = ~out_valid[i] | out_ready[i] (slot empty, or draining this cycle).
- in_ready is combinational:
  - in_bcast=1: AND of free_i over all i.
  - in_bcast=0, in_sel<N: free_[in_sel].
  - in_bcast=0, in_sel>=N: 1 (drop path never stalls).
- in_ready must not depend on in_valid (no valid->ready loop). It does depend combinationally on out_ready.
- Accept event: acc = in_valid & in_ready.
- Per slot i, each clock edge:
  - load_i = acc & (in_bcast | (in_sel==i)).
  - If load_i: valid_i<=1, data_i<=in_data.
  - Else if out_ready[i]: valid_i<=0; data_i holds.
  - Else: hold.
  - Simultaneous drain and load on the same slot: load wins. Valid stays 1 and the new data replaces the old, giving full throughput of 1 word/cycle/channel.
- Latency: accepted word appears on out_valid/out_data the cycle after acceptance.
- Broadcast: all N slots load the same word in one cycle. It is all-or-nothing and waits until every slot is free; no partial delivery.
- Out-of-range select (only possible when N is not a power of two): the word is accepted and discarded, no slot changes, and sel_err=1 on the following cycle only.
- sel_err is a registered pulse: sel_err <= acc & ~in_bcast & (in_sel>=N).
- out_data of an invalid slot retains its last value; consumers ignore it.
- Reset mid-operation: all buffered words are lost, out_valid clears the next edge, and no sel_err pulse follows reset.
- No ordering guarantee between channels; ordering is preserved within a channel.

Decomposition:
- Package demux_stream_pkg:
  - default DW/N constants.
  - function for slot bit-slice offset.
  - no typedefs needed beyond a DW-wide data type.
- Sub-module demux_slot:
  - One-entry register with load/drain logic.
  - Ports: clk, rst_n, load, din, out_ready, out_valid, dout, free.
  - Instantiated N times by a generate loop.
- Top-level holds: in_ready reduction, select decode, sel_err register.

Test Plan:
1. Reset then single routing: DW=8,N=8; rst_n=0 for 2 cycles, then in_valid=1, in_sel=3, in_data=0xA5, all out_ready=0 -> in_ready=1; next cycle out_valid=8'b0000_1000, channel 3 data=0xA5; other valids 0.
2. Back-pressure: continuing case 1, send second word 0x5A to sel=3 with out_ready[3]=0 -> in_ready=0, word held; raise out_ready[3] -> same cycle in_ready=1, next cycle channel 3 data=0x5A, valid stays 1 (drain+load).
3. Full throughput: sel=0, out_ready[0]=1, stream 0x01..0x10 back-to-back -> in_ready=1 every cycle; channel 0 shows 0x01..0x10 on consecutive cycles, no gaps or duplicates.
4. Broadcast blocking: out_valid[5]=1 with out_ready[5]=0; in_bcast=1, in_data=0xFF -> in_ready=0, no slot changes. Release out_ready[5] -> next cycle out_valid=8'hFF, all channels 0xFF.
5. Out-of-range: N=5 (SW=3); in_sel=6, in_data=0x33, in_valid=1 -> in_ready=1, sel_err=1 next cycle for exactly one cycle, out_valid unchanged.
6. Reset mid-operation: load channels 1 and 2 with out_ready=0, then assert rst_n=0 one cycle -> out_valid=0, out_data=0, sel_err=0 after that edge; traffic resumes normally after release.

Source files
------------

// File: rtl/demux_stream_pkg.sv
// Shared constants and helpers for the registered 1-to-N stream demultiplexer.
package demux_stream_pkg;

    localparam int DW_DEFAULT = 8;
    localparam int N_DEFAULT  = 8;

    typedef logic [DW_DEFAULT-1:0] data_t;

    // LSB position of channel idx inside the flattened N*DW output bus.
    function automatic int slot_lsb(input int idx, input int dw);
        return idx * dw;
    endfunction

endpackage

// File: rtl/demux_stream_n_if.sv
// Producer/consumer bundle for demux_stream_n: one input stream, N output streams.
interface demux_stream_n_if
    import demux_stream_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int N  = N_DEFAULT
);

    localparam int SW = $clog2(N);

    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic [SW-1:0]   in_sel;
    logic            in_bcast;
    logic [N-1:0]    out_valid;
    logic [N-1:0]    out_ready;
    logic [N*DW-1:0] out_data;
    logic            sel_err;

    modport master (
        output in_valid, in_data, in_sel, in_bcast, out_ready,
        input  in_ready, out_valid, out_data, sel_err
    );

    modport slave (
        input  in_valid, in_data, in_sel, in_bcast, out_ready,
        output in_ready, out_valid, out_data, sel_err
    );

endinterface

// File: rtl/demux_slot.sv
// One-entry output register for a single demux channel. A load in the same
// cycle as a drain keeps the slot full, so a channel sustains one word/cycle.
module demux_slot #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [DW-1:0] din,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [DW-1:0] dout,
    output logic          free
);

    logic          valid_q, valid_d;
    logic [DW-1:0] data_q,  data_d;

    // Next-state: load beats drain; data is kept when the slot empties.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = din;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Slot register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign dout      = data_q;
    assign free      = ~valid_q | out_ready;

endmodule

// File: rtl/demux_stream_n.sv
// Registered 1-to-N stream demux with broadcast and out-of-range select drop.
// in_ready depends on in_sel/in_bcast/out_ready only, never on in_valid.
module demux_stream_n
    import demux_stream_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int N  = N_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    demux_stream_n_if.slave bus
);

    logic [N-1:0]    free;
    logic [N-1:0]    load;
    logic [N-1:0]    valid_w;
    logic [N*DW-1:0] data_w;
    logic            sel_oob;
    logic            ready;
    logic            acc;
    logic            sel_err_q, sel_err_d;

    // Ready decode: broadcast needs every slot, a bad select is always taken.
    always_comb begin
        sel_oob = (32'(bus.in_sel) >= N);
        ready   = 1'b1;
        if (bus.in_bcast) begin
            ready = &free;
        end else if (!sel_oob) begin
            ready = free[bus.in_sel];
        end
    end

    assign acc = bus.in_valid & ready;

    for (genvar i = 0; i < N; i++) begin : g_slot
        assign load[i] = acc & (bus.in_bcast | (32'(bus.in_sel) == i));

        demux_slot #(.DW(DW)) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[i]),
            .din       (bus.in_data),
            .out_ready (bus.out_ready[i]),
            .out_valid (valid_w[i]),
            .dout      (data_w[slot_lsb(i, DW) +: DW]),
            .free      (free[i])
        );
    end

    assign sel_err_d = acc & ~bus.in_bcast & sel_oob;

    // One-cycle pulse for each dropped word; cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = valid_w;
    assign bus.out_data  = data_w;
    assign bus.sel_err   = sel_err_q;

endmodule

// File: tb/tb_demux_stream_n.sv
// Directed bench for demux_stream_n: an N=8 instance for routing, throughput,
// broadcast and reset, and an N=5 instance for the out-of-range select path.
module tb_demux_stream_n;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    demux_stream_n_if #(.DW(8), .N(8)) ifa ();
    demux_stream_n_if #(.DW(8), .N(5)) ifb ();

    demux_stream_n #(.DW(8), .N(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    demux_stream_n #(.DW(8), .N(5)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] qa [8][$];
    logic [7:0] qb [5][$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every output handshake must match the oldest pushed word.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 8; i++) begin
                if (ifa.out_valid[i] && ifa.out_ready[i]) begin
                    chk($sformatf("a_sb_nonempty_ch%0d", i), 64'(qa[i].size() != 0), 64'd1);
                    if (qa[i].size() != 0)
                        chk($sformatf("a_sb_data_ch%0d", i), 64'(ifa.out_data[i*8 +: 8]), 64'(qa[i].pop_front()));
                end
            end
            for (int i = 0; i < 5; i++) begin
                if (ifb.out_valid[i] && ifb.out_ready[i]) begin
                    chk($sformatf("b_sb_nonempty_ch%0d", i), 64'(qb[i].size() != 0), 64'd1);
                    if (qb[i].size() != 0)
                        chk($sformatf("b_sb_data_ch%0d", i), 64'(ifb.out_data[i*8 +: 8]), 64'(qb[i].pop_front()));
                end
            end
        end
    end

    initial begin
        rst_n         = 1'b0;
        ifa.in_valid  = 1'b0;
        ifa.in_data   = '0;
        ifa.in_sel    = '0;
        ifa.in_bcast  = 1'b0;
        ifa.out_ready = '0;
        ifb.in_valid  = 1'b0;
        ifb.in_data   = '0;
        ifb.in_sel    = '0;
        ifb.in_bcast  = 1'b0;
        ifb.out_ready = '0;

        // Reset
        cyc();
        cyc();
        chk("rst_a_valid", 64'(ifa.out_valid), 64'h0);
        chk("rst_a_data",  64'(ifa.out_data),  64'h0);
        chk("rst_a_err",   64'(ifa.sel_err),   64'h0);
        chk("rst_b_valid", 64'(ifb.out_valid), 64'h0);
        chk("rst_b_err",   64'(ifb.sel_err),   64'h0);
        rst_n = 1'b1;

        // Single routing to channel 3
        ifa.in_valid = 1'b1;
        ifa.in_sel   = 3'd3;
        ifa.in_data  = 8'hA5;
        #1 chk("t1_ready", 64'(ifa.in_ready), 64'h1);
        qa[3].push_back(8'hA5);
        cyc();
        ifa.in_data = 8'h5A;
        #1;
        chk("t1_valid", 64'(ifa.out_valid), 64'h08);
        chk("t1_data3", 64'(ifa.out_data[31:24]), 64'hA5);
        chk("t2_ready_blocked", 64'(ifa.in_ready), 64'h0);

        // Back-pressure then drain+load
        cyc();
        chk("t2_hold_valid", 64'(ifa.out_valid), 64'h08);
        chk("t2_hold_data",  64'(ifa.out_data[31:24]), 64'hA5);
        ifa.out_ready = 8'h08;
        #1 chk("t2_ready_drain", 64'(ifa.in_ready), 64'h1);
        qa[3].push_back(8'h5A);
        cyc();
        ifa.in_valid = 1'b0;
        #1;
        chk("t2_valid_kept", 64'(ifa.out_valid), 64'h08);
        chk("t2_data3",      64'(ifa.out_data[31:24]), 64'h5A);
        cyc();
        chk("t2_empty", 64'(ifa.out_valid), 64'h0);

        // Full throughput on channel 0
        ifa.out_ready = 8'h01;
        ifa.in_sel    = 3'd0;
        for (int k = 1; k <= 16; k++) begin
            ifa.in_valid = 1'b1;
            ifa.in_data  = 8'(k);
            #1 chk($sformatf("t3_ready_%0d", k), 64'(ifa.in_ready), 64'h1);
            qa[0].push_back(8'(k));
            cyc();
            chk($sformatf("t3_valid_%0d", k), 64'(ifa.out_valid), 64'h01);
            chk($sformatf("t3_data_%0d", k), 64'(ifa.out_data[7:0]), 64'(k));
        end
        ifa.in_valid = 1'b0;
        cyc();
        chk("t3_drained", 64'(ifa.out_valid), 64'h0);
        ifa.out_ready = 8'h00;

        // Broadcast blocked by a full channel 5
        ifa.in_sel   = 3'd5;
        ifa.in_data  = 8'h55;
        ifa.in_valid = 1'b1;
        #1 chk("t4_load_ready", 64'(ifa.in_ready), 64'h1);
        qa[5].push_back(8'h55);
        cyc();
        ifa.in_bcast = 1'b1;
        ifa.in_data  = 8'hFF;
        #1;
        chk("t4_pre_valid",     64'(ifa.out_valid), 64'h20);
        chk("t4_bcast_blocked", 64'(ifa.in_ready),  64'h0);
        cyc();
        chk("t4_no_change",     64'(ifa.out_valid), 64'h20);
        chk("t4_ch5_data",      64'(ifa.out_data[47:40]), 64'h55);
        chk("t4_still_blocked", 64'(ifa.in_ready),  64'h0);
        ifa.out_ready = 8'h20;
        #1 chk("t4_bcast_ready", 64'(ifa.in_ready), 64'h1);
        for (int i = 0; i < 8; i++) qa[i].push_back(8'hFF);
        cyc();
        ifa.in_valid  = 1'b0;
        ifa.in_bcast  = 1'b0;
        ifa.out_ready = 8'h00;
        #1;
        chk("t4_all_valid", 64'(ifa.out_valid), 64'hFF);
        chk("t4_all_data",  64'(ifa.out_data),  {8{8'hFF}});
        ifa.out_ready = 8'hFF;
        cyc();
        chk("t4_drained", 64'(ifa.out_valid), 64'h0);
        ifa.out_ready = 8'h00;

        // Reset mid-operation
        ifa.in_sel   = 3'd1;
        ifa.in_data  = 8'h11;
        ifa.in_valid = 1'b1;
        #1 chk("t6_ready1", 64'(ifa.in_ready), 64'h1);
        qa[1].push_back(8'h11);
        cyc();
        ifa.in_sel  = 3'd2;
        ifa.in_data = 8'h22;
        #1 chk("t6_ready2", 64'(ifa.in_ready), 64'h1);
        qa[2].push_back(8'h22);
        cyc();
        ifa.in_valid = 1'b0;
        #1 chk("t6_loaded", 64'(ifa.out_valid), 64'h06);
        rst_n = 1'b0;
        cyc();
        chk("t6_rst_valid", 64'(ifa.out_valid), 64'h0);
        chk("t6_rst_data",  64'(ifa.out_data),  64'h0);
        chk("t6_rst_err",   64'(ifa.sel_err),   64'h0);
        qa[1].delete();
        qa[2].delete();
        rst_n = 1'b1;
        ifa.in_sel   = 3'd7;
        ifa.in_data  = 8'h77;
        ifa.in_valid = 1'b1;
        #1 chk("t6_resume_ready", 64'(ifa.in_ready), 64'h1);
        qa[7].push_back(8'h77);
        cyc();
        ifa.in_valid = 1'b0;
        chk("t6_resume_valid", 64'(ifa.out_valid), 64'h80);
        chk("t6_resume_data",  64'(ifa.out_data[63:56]), 64'h77);
        ifa.out_ready = 8'hFF;
        cyc();
        chk("t6_resume_drained", 64'(ifa.out_valid), 64'h0);
        chk("t6_no_err", 64'(ifa.sel_err), 64'h0);
        ifa.out_ready = 8'h00;

        // Out-of-range select on the N=5 instance
        ifb.in_sel   = 3'd2;
        ifb.in_data  = 8'h44;
        ifb.in_valid = 1'b1;
        #1 chk("t5_load_ready", 64'(ifb.in_ready), 64'h1);
        qb[2].push_back(8'h44);
        cyc();
        ifb.in_sel  = 3'd6;
        ifb.in_data = 8'h33;
        #1;
        chk("t5_oob_ready", 64'(ifb.in_ready),  64'h1);
        chk("t5_pre_valid", 64'(ifb.out_valid), 64'h04);
        cyc();
        ifb.in_valid = 1'b0;
        #1;
        chk("t5_err",       64'(ifb.sel_err),   64'h1);
        chk("t5_valid_same", 64'(ifb.out_valid), 64'h04);
        chk("t5_ch2_data",  64'(ifb.out_data[23:16]), 64'h44);
        cyc();
        chk("t5_err_end",   64'(ifb.sel_err),   64'h0);
        chk("t5_valid_same2", 64'(ifb.out_valid), 64'h04);

        // Highest legal select
        ifb.in_sel   = 3'd4;
        ifb.in_data  = 8'h4C;
        ifb.in_valid = 1'b1;
        #1 chk("t5_sel4_ready", 64'(ifb.in_ready), 64'h1);
        qb[4].push_back(8'h4C);
        cyc();
        ifb.in_valid = 1'b0;
        chk("t5_sel4_valid", 64'(ifb.out_valid), 64'h14);
        chk("t5_sel4_err",   64'(ifb.sel_err),   64'h0);
        chk("t5_sel4_data",  64'(ifb.out_data[39:32]), 64'h4C);

        // Lowest illegal select
        ifb.in_sel   = 3'd5;
        ifb.in_data  = 8'h99;
        ifb.in_valid = 1'b1;
        #1 chk("t5_sel5_ready", 64'(ifb.in_ready), 64'h1);
        cyc();
        ifb.in_valid = 1'b0;
        chk("t5_sel5_err",   64'(ifb.sel_err),   64'h1);
        chk("t5_sel5_valid", 64'(ifb.out_valid), 64'h14);

        // Broadcast ignores an out-of-range select
        ifb.in_bcast = 1'b1;
        ifb.in_sel   = 3'd7;
        ifb.in_data  = 8'hAB;
        ifb.in_valid = 1'b1;
        #1 chk("t5_bcast_blocked", 64'(ifb.in_ready), 64'h0);
        cyc();
        chk("t5_bcast_wait_err", 64'(ifb.sel_err), 64'h0);
        ifb.out_ready = 5'h1F;
        #1 chk("t5_bcast_ready", 64'(ifb.in_ready), 64'h1);
        for (int i = 0; i < 5; i++) qb[i].push_back(8'hAB);
        cyc();
        ifb.in_valid = 1'b0;
        ifb.in_bcast = 1'b0;
        #1;
        chk("t5_bcast_err",   64'(ifb.sel_err),   64'h0);
        chk("t5_bcast_valid", 64'(ifb.out_valid), 64'h1F);
        chk("t5_bcast_data",  64'(ifb.out_data),  64'({5{8'hAB}}));
        cyc();
        chk("t5_bcast_drained", 64'(ifb.out_valid), 64'h0);
        ifb.out_ready = 5'h00;

        // A dropped word during reset must not pulse sel_err afterwards
        ifb.in_sel   = 3'd6;
        ifb.in_valid = 1'b1;
        rst_n        = 1'b0;
        cyc();
        chk("t7_rst_err", 64'(ifb.sel_err), 64'h0);
        rst_n        = 1'b1;
        ifb.in_valid = 1'b0;
        cyc();
        chk("t7_post_rst_err", 64'(ifb.sel_err), 64'h0);

        for (int i = 0; i < 8; i++)
            chk($sformatf("end_a_q%0d_empty", i), 64'(qa[i].size()), 64'h0);
        for (int i = 0; i < 5; i++)
            chk($sformatf("end_b_q%0d_empty", i), 64'(qb[i].size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
